key_schedule_ctrl: RTL and testbench

//   Iterative AES-128 key-schedule sequencer: takes one cipher key and runs one shared round-key

---
 rtl/key_schedule_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES-128 key-schedule sequencer.
// A single shared round step (g-function, then the word XOR chain) is reused
// over NUM_ROUNDS rounds. All round keys are kept in an internal bank, which
// the cipher datapath reads by round index with a one-cycle latency.
// Optional feature macro: KEY_SCHED_ZEROIZE_EN adds a WIPE state that clears
// the bank one entry per cycle when i_zeroize is asserted.

package def_pkg;

  // GF(2^8) multiply, reduction polynomial x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      if (aa[7]) begin
        aa = {aa[6:0], 1'b0} ^ 8'h1b;
      end else begin
        aa = {aa[6:0], 1'b0};
      end
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // AES forward S-box: field inverse followed by the affine transform
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Multiply by x in GF(2^8); advances the round constant (80 -> 1B)
  function automatic logic [7:0] xtime(input logic [7:0] v);
    if (v[7]) begin
      return {v[6:0], 1'b0} ^ 8'h1b;
    end else begin
      return {v[6:0], 1'b0};
    end
  endfunction

endpackage

module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_key_valid,
  input  logic [127:0] i_key,
  output logic         o_key_ready,
  output logic         o_busy,
  output logic         o_keys_ready,
  input  logic         i_rd_en,
  input  logic [3:0]   i_rd_round,
  output logic         o_rd_valid,
  output logic [127:0] o_rd_key,
  output logic         o_rd_err,
  input  logic         i_zeroize
);

  import def_pkg::*;

  localparam int         IDX_W      = $clog2(NUM_ROUNDS + 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

`ifdef KEY_SCHED_ZEROIZE_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_G    = 3'd1,
    ST_XOR  = 3'd2,
    ST_DONE = 3'd3,
    ST_WIPE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_G    = 3'd1,
    ST_XOR  = 3'd2,
    ST_DONE = 3'd3
  } state_t;
`endif

  state_t             state_r;
  state_t             state_nxt_s;
  logic               key_ready_r;
  logic               busy_r;
  logic               keys_ready_r;
  logic               key_ready_nxt_s;
  logic               busy_nxt_s;
  logic               keys_ready_nxt_s;
  logic [127:0]       work_r;
  logic [31:0]        g_r;
  logic [7:0]         rcon_r;
  logic [3:0]         round_r;
  logic [31:0]        g_s;
  logic [31:0]        w0_s;
  logic [31:0]        w1_s;
  logic [31:0]        w2_s;
  logic [31:0]        w3_s;
  logic [127:0]       new_key_s;
  logic               accept_s;
  logic               abort_s;
  logic               bank_we_s;
  logic [IDX_W-1:0]   bank_waddr_s;
  logic [127:0]       bank_wdata_s;
  logic [127:0]       bank_r [0:NUM_ROUNDS];
  logic               rd_valid_r;
  logic               rd_err_r;
  logic [127:0]       rd_key_r;

`ifdef KEY_SCHED_ZEROIZE_EN
  logic [3:0]         wipe_cnt_r;
  // Wipe request outranks a key offered on the same edge
  assign accept_s = i_key_valid & key_ready_r & ~i_zeroize;
  assign abort_s  = reset | i_zeroize;
`else
  logic               zeroize_unused_s;
  assign zeroize_unused_s = i_zeroize;
  assign accept_s = i_key_valid & key_ready_r;
  assign abort_s  = reset;
`endif

  // g-function on the last word of the working key
  assign g_s = {aes_sbox(work_r[23:16]) ^ rcon_r, aes_sbox(work_r[15:8]),
                aes_sbox(work_r[7:0]), aes_sbox(work_r[31:24])};

  // Word XOR chain producing the next round key from the registered g
  assign w0_s      = work_r[127:96] ^ g_r;
  assign w1_s      = work_r[95:64]  ^ w0_s;
  assign w2_s      = work_r[63:32]  ^ w1_s;
  assign w3_s      = work_r[31:0]   ^ w2_s;
  assign new_key_s = {w0_s, w1_s, w2_s, w3_s};

  // FSM state and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      keys_ready_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      key_ready_r  <= key_ready_nxt_s;
      busy_r       <= busy_nxt_s;
      keys_ready_r <= keys_ready_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nxt_s = ST_G;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_G:   state_nxt_s = ST_XOR;
      ST_XOR: begin
        if (round_r == LAST_ROUND) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_G;
        end
      end
`ifdef KEY_SCHED_ZEROIZE_EN
      ST_WIPE: begin
        if (wipe_cnt_r == LAST_ROUND) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WIPE;
        end
      end
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
`ifdef KEY_SCHED_ZEROIZE_EN
    if (i_zeroize) begin
      state_nxt_s = ST_WIPE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
`endif
  end

  // FSM output logic: next values of the registered status flags
  always_comb begin
    key_ready_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
    busy_nxt_s      = !key_ready_nxt_s;
    if (state_nxt_s == ST_DONE) begin
      keys_ready_nxt_s = 1'b1;
    end else if (busy_nxt_s) begin
      keys_ready_nxt_s = 1'b0;
    end else begin
      keys_ready_nxt_s = keys_ready_r;
    end
  end

  // Working key, g, round constant and round counter
  always_ff @(posedge clock) begin
    if (reset) begin
      work_r     <= 128'h0;
      g_r        <= 32'h0;
      rcon_r     <= 8'h01;
      round_r    <= 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
      wipe_cnt_r <= 4'd0;
`endif
    end else begin
`ifdef KEY_SCHED_ZEROIZE_EN
      if (i_zeroize) begin
        work_r     <= 128'h0;
        g_r        <= 32'h0;
        rcon_r     <= 8'h00;
        round_r    <= 4'd0;
        wipe_cnt_r <= 4'd0;
      end else
`endif
      if (accept_s) begin
        work_r  <= i_key;
        round_r <= 4'd1;
        rcon_r  <= 8'h01;
      end else begin
        case (state_r)
          ST_G: g_r <= g_s;
          ST_XOR: begin
            work_r  <= new_key_s;
            rcon_r  <= xtime(rcon_r);
            round_r <= round_r + 4'd1;
          end
`ifdef KEY_SCHED_ZEROIZE_EN
          ST_WIPE: wipe_cnt_r <= wipe_cnt_r + 4'd1;
`endif
          default: round_r <= round_r;
        endcase
      end
    end
  end

  // Key bank write port: cipher key, expanded round keys, or wipe zeros
  always_comb begin
    bank_we_s    = 1'b0;
    bank_waddr_s = {IDX_W{1'b0}};
    bank_wdata_s = 128'h0;
    if (abort_s) begin
      bank_we_s = 1'b0;
    end else if (accept_s) begin
      bank_we_s    = 1'b1;
      bank_wdata_s = i_key;
    end else if (state_r == ST_XOR) begin
      bank_we_s    = 1'b1;
      bank_waddr_s = round_r[IDX_W-1:0];
      bank_wdata_s = new_key_s;
`ifdef KEY_SCHED_ZEROIZE_EN
    end else if (state_r == ST_WIPE) begin
      bank_we_s    = 1'b1;
      bank_waddr_s = wipe_cnt_r[IDX_W-1:0];
`endif
    end else begin
      bank_we_s = 1'b0;
    end
  end

  // Key bank storage; deliberately not cleared by reset
  always_ff @(posedge clock) begin
    if (bank_we_s) begin
      bank_r[bank_waddr_s] <= bank_wdata_s;
    end
  end

  // Registered read port; refuses reads until a full schedule is present
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      rd_key_r   <= 128'h0;
    end else if (i_rd_en) begin
      rd_valid_r <= 1'b1;
      if (keys_ready_r && (i_rd_round <= LAST_ROUND)) begin
        rd_key_r <= bank_r[i_rd_round[IDX_W-1:0]];
        rd_err_r <= 1'b0;
      end else begin
        rd_key_r <= 128'h0;
        rd_err_r <= 1'b1;
      end
    end else begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
    end
  end

  assign o_key_ready  = key_ready_r;
  assign o_busy       = busy_r;
  assign o_keys_ready = keys_ready_r;
  assign o_rd_valid   = rd_valid_r;
  assign o_rd_err     = rd_err_r;
  assign o_rd_key     = rd_key_r;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: directed steps plus random keys,
// checked against a FIPS-197 style word-array key expansion model.
module tb_key_schedule_ctrl;

  localparam int NR = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         i_key_valid = 1'b0;
  logic [127:0] i_key = 128'h0;
  logic         o_key_ready;
  logic         o_busy;
  logic         o_keys_ready;
  logic         i_rd_en = 1'b0;
  logic [3:0]   i_rd_round = 4'd0;
  logic         o_rd_valid;
  logic [127:0] o_rd_key;
  logic         o_rd_err;
  logic         i_zeroize = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;

  logic [127:0] exp_keys [0:NR];
  logic [2047:0] sbox_flat;

  key_schedule_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_key_valid  (i_key_valid),
    .i_key        (i_key),
    .o_key_ready  (o_key_ready),
    .o_busy       (o_busy),
    .o_keys_ready (o_keys_ready),
    .i_rd_en      (i_rd_en),
    .i_rd_round   (i_rd_round),
    .o_rd_valid   (o_rd_valid),
    .o_rd_key     (o_rd_key),
    .o_rd_err     (o_rd_err),
    .i_zeroize    (i_zeroize)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_flat[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Reference expansion: 44-word array as in FIPS-197
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) begin
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_key_ready"}, o_key_ready, 1'b1);
    chk1({tag, "_busy"}, o_busy, 1'b0);
    chk1({tag, "_keys_ready"}, o_keys_ready, 1'b0);
    chk1({tag, "_rd_valid"}, o_rd_valid, 1'b0);
    chk1({tag, "_rd_err"}, o_rd_err, 1'b0);
    chk({tag, "_rd_key"}, o_rd_key, 128'h0);
  endtask

  task automatic accept(input logic [127:0] k);
    chk1("key_ready_pre_accept", o_key_ready, 1'b1);
    i_key_valid = 1'b1;
    i_key       = k;
    tick();
    i_key_valid = 1'b0;
    t_acc       = cyc;
    chk1("busy_after_accept", o_busy, 1'b1);
    chk1("key_ready_after_accept", o_key_ready, 1'b0);
    chk1("keys_ready_after_accept", o_keys_ready, 1'b0);
  endtask

  task automatic wait_done();
    int lim;
    lim = 0;
    while (!o_keys_ready && lim < 60) begin
      tick();
      lim++;
    end
    chk("done_latency", 128'(cyc - t_acc), 128'(2 * NR));
    chk1("busy_at_done", o_busy, 1'b0);
    chk1("key_ready_at_done", o_key_ready, 1'b1);
  endtask

  task automatic rd(input int idx, input logic sched_ok);
    logic         ee;
    logic [127:0] ek;
    i_rd_en    = 1'b1;
    i_rd_round = 4'(idx);
    tick();
    i_rd_en = 1'b0;
    ee = !(sched_ok && idx <= NR);
    if (ee) begin
      ek = 128'h0;
    end else begin
      ek = exp_keys[idx];
    end
    chk1($sformatf("rd_valid_r%0d", idx), o_rd_valid, 1'b1);
    chk1($sformatf("rd_err_r%0d", idx), o_rd_err, ee);
    chk($sformatf("rd_key_r%0d", idx), o_rd_key, ek);
  endtask

  task automatic verify_all();
    int off;
    off = int'($urandom_range(0, NR + 1));
    for (int k = 0; k < NR + 2; k++) begin
      rd((k + off) % (NR + 2), 1'b1);
    end
  endtask

  initial begin
    logic [127:0] k;
    int t_w;
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    rd(0, 1'b0);

    // FIPS-197 known-answer key
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(k);
    accept(k);
    wait_done();
    verify_all();
    rd(11, 1'b1);
    rd(1, 1'b1);
    chk("fips_round1", o_rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(10, 1'b1);
    chk("fips_round10", o_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk1("idle_rd_valid", o_rd_valid, 1'b0);
    chk1("idle_rd_err", o_rd_err, 1'b0);
    chk("idle_rd_key_hold", o_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Read while busy and key offered while busy
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    accept(k);
    tick();
    rd(3, 1'b0);
    i_key_valid = 1'b1;
    i_key       = {$urandom, $urandom, $urandom, $urandom};
    tick();
    i_key_valid = 1'b0;
    chk1("busy_after_ignored_key", o_busy, 1'b1);
    wait_done();
    verify_all();

    // Reset in the middle of an expansion
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    accept(k);
    while (cyc < t_acc + 6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs("midreset");
    rd(0, 1'b0);
    accept(k);
    wait_done();
    verify_all();

    // All-zero key, then a back-to-back key with a same-edge read
    model_expand(128'h0);
    accept(128'h0);
    wait_done();
    k = {$urandom, $urandom, $urandom, $urandom};
    i_rd_en     = 1'b1;
    i_rd_round  = 4'd1;
    i_key_valid = 1'b1;
    i_key       = k;
    tick();
    t_acc       = cyc;
    i_rd_en     = 1'b0;
    i_key_valid = 1'b0;
    chk1("b2b_rd_valid", o_rd_valid, 1'b1);
    chk1("b2b_rd_err", o_rd_err, 1'b0);
    chk("zero_key_round1", o_rd_key, 128'h62636363626363636263636362636363);
    chk1("b2b_busy", o_busy, 1'b1);
    chk1("b2b_keys_ready", o_keys_ready, 1'b0);
    model_expand(k);
    wait_done();
    verify_all();

    // Random keys
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      accept(k);
      wait_done();
      verify_all();
    end

`ifdef KEY_SCHED_ZEROIZE_EN
    // Zeroize mid-expansion
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    accept(k);
    while (cyc < t_acc + 4) tick();
    i_zeroize = 1'b1;
    tick();
    i_zeroize = 1'b0;
    t_w = cyc;
    chk1("wipe_busy", o_busy, 1'b1);
    chk1("wipe_key_ready", o_key_ready, 1'b0);
    chk1("wipe_keys_ready", o_keys_ready, 1'b0);
    while (!o_key_ready && cyc < t_w + 40) tick();
    chk("wipe_length", 128'(cyc - t_w), 128'(NR + 1));
    rd(0, 1'b0);
    accept(k);
    wait_done();
    verify_all();
`else
    t_w = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
